// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Two forwarding muxes (rs -> A, rt -> store data / B) share one per-operand sub-module.

module id_ex_fwd (
    input  logic [4:0]  idx,
    input  logic [31:0] regval,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_wreg,
    input  logic [31:0] mem_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_wreg,
    input  logic [31:0] wb_result,
    output logic [31:0] val
);
    logic mem_hit;
    logic wb_hit;

    // $0 is hardwired, so a write to index 0 must never be forwarded
    assign mem_hit = mem_regwrite && (mem_wreg != 5'd0) && (mem_wreg == idx);
    assign wb_hit  = wb_regwrite  && (wb_wreg  != 5'd0) && (wb_wreg  == idx);

    always_comb begin
        val = regval;
        if (mem_hit)
            val = mem_result;
        else if (wb_hit)
            val = wb_result;
    end
endmodule

module id_ex_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hold,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [2:0]  id_ctrl,
    input  logic        id_alusrc,
    input  logic [4:0]  id_aluop,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_wreg,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_wreg,
    input  logic [31:0] mem_result,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_wreg,
    input  logic [31:0] wb_result,
    output logic        ex_valid,
    output logic [2:0]  ex_ctrl,
    output logic [4:0]  ex_aluop,
    output logic [4:0]  ex_wreg,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [31:0] ex_store_data,
    output logic        load_use
);
    localparam int NUM_SRC = 2;

    logic        valid_r;
    logic [2:0]  ctrl_r;
    logic        alusrc_r;
    logic [4:0]  aluop_r;
    logic [4:0]  rs_r;
    logic [4:0]  rt_r;
    logic [4:0]  wreg_r;
    logic [31:0] rd1_r;
    logic [31:0] rd2_r;
    logic [31:0] imm_r;

    logic [NUM_SRC-1:0][4:0]  src_idx;
    logic [NUM_SRC-1:0][31:0] src_val;
    logic [NUM_SRC-1:0][31:0] fwd_val;

    // A bubble (flush or invalid decode) clears every field, not just valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r  <= 1'b0;
            ctrl_r   <= 3'd0;
            alusrc_r <= 1'b0;
            aluop_r  <= 5'd0;
            rs_r     <= 5'd0;
            rt_r     <= 5'd0;
            wreg_r   <= 5'd0;
            rd1_r    <= 32'd0;
            rd2_r    <= 32'd0;
            imm_r    <= 32'd0;
        end else if (flush || (!hold && !id_valid)) begin
            valid_r  <= 1'b0;
            ctrl_r   <= 3'd0;
            alusrc_r <= 1'b0;
            aluop_r  <= 5'd0;
            rs_r     <= 5'd0;
            rt_r     <= 5'd0;
            wreg_r   <= 5'd0;
            rd1_r    <= 32'd0;
            rd2_r    <= 32'd0;
            imm_r    <= 32'd0;
        end else if (!hold) begin
            valid_r  <= 1'b1;
            ctrl_r   <= id_ctrl;
            alusrc_r <= id_alusrc;
            aluop_r  <= id_aluop;
            rs_r     <= id_rs;
            rt_r     <= id_rt;
            wreg_r   <= id_wreg;
            rd1_r    <= id_rd1;
            rd2_r    <= id_rd2;
            imm_r    <= id_imm;
        end
    end

    assign src_idx[0] = rs_r;
    assign src_idx[1] = rt_r;
    assign src_val[0] = rd1_r;
    assign src_val[1] = rd2_r;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_fwd
            id_ex_fwd u_fwd (
                .idx          (src_idx[g]),
                .regval       (src_val[g]),
                .mem_regwrite (mem_regwrite),
                .mem_wreg     (mem_wreg),
                .mem_result   (mem_result),
                .wb_regwrite  (wb_regwrite),
                .wb_wreg      (wb_wreg),
                .wb_result    (wb_result),
                .val          (fwd_val[g])
            );
        end
    endgenerate

    assign ex_valid      = valid_r;
    assign ex_ctrl       = valid_r ? ctrl_r : 3'd0;
    assign ex_aluop      = aluop_r;
    assign ex_wreg       = wreg_r;
    assign ex_A          = fwd_val[0];
    assign ex_store_data = fwd_val[1];
    assign ex_B          = alusrc_r ? imm_r : fwd_val[1];

    // Built from registered state and id_* only, so the controller may drive flush from it
    assign load_use = valid_r && ctrl_r[1] && (wreg_r != 5'd0) && id_valid &&
                      ((wreg_r == id_rs) || (wreg_r == id_rt));
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (32-bit datapath, 5-bit register indices, 5-bit ALUOp).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 hold  input  1  freeze: keep all stage registers unchanged.
REQ-005 flush  input  1  load a bubble on the next edge.
REQ-006 id_valid  input  1  decode stage holds a valid instruction.
REQ-007 id_ctrl  input  3  {regwrite, memread, memwrite} from decode.
REQ-008 id_alusrc  input  1  1 selects id_imm as the ALU B operand.
REQ-009 id_aluop  input  5  ALUOp code, passed through unmodified.
REQ-010 id_rs, id_rt  input  5 each  source register indices.
REQ-011 id_wreg  input  5  destination register index.
REQ-012 id_rd1, id_rd2  input  32 each  register-file read data.
REQ-013 id_imm  input  32  extended immediate; bits [10:6] carry shamt for shifts.
REQ-014 mem_regwrite, mem_wreg, mem_result  input  1/5/32  MEM-stage forwarding source.
REQ-015 wb_regwrite, wb_wreg, wb_result  input  1/5/32  WB-stage forwarding source.
REQ-016 ex_valid  output  1  EX holds a valid instruction.
REQ-017 ex_ctrl  output  3  latched {regwrite, memread, memwrite}, gated by ex_valid.
REQ-018 ex_aluop  output  5  latched ALUOp, drives the ALU ALUOp input.
REQ-019 ex_wreg  output  5  latched destination index.
REQ-020 ex_A, ex_B  output  32 each  forwarded ALU operands A and B.
REQ-021 ex_store_data  output  32  forwarded rt value for stores.
REQ-022 load_use  output  1  combinational load-use hazard request to the pipeline controller.

Function
REQ-023 On each rising edge with rstn=1: if flush=1, a bubble SHALL be loaded (ex_valid=0, ex_ctrl=0, all other fields 0); else if hold=1, all registers SHALL keep their values; else all id_* fields SHALL be latched.
REQ-024 flush SHALL take priority over hold when both are 1.
REQ-025 Latency SHALL be one cycle from id_* to the corresponding ex_* output.
REQ-026 ex_ctrl SHALL be forced to 0 whenever ex_valid=0; id_valid=0 SHALL latch as a bubble.
REQ-027 Forwarding SHALL be combinational from the latched rs/rt and the current mem_*/wb_* inputs; per operand: if mem_regwrite=1, mem_wreg!=0 and mem_wreg==index, select mem_result; else if the same holds for wb_*, select wb_result; else select the latched register value.
REQ-028 MEM-stage forwarding SHALL win over WB when both match; index 0 SHALL never be forwarded.
REQ-029 ex_A SHALL be the forwarded rs value; ex_store_data SHALL be the forwarded rt value.
REQ-030 ex_B SHALL be the latched imm when the latched alusrc=1, else the forwarded rt value.
REQ-031 load_use SHALL be 1 iff ex_valid=1, ex_ctrl memread=1, ex_wreg!=0, id_valid=1, and ex_wreg equals id_rs or id_rt; the controller answers with flush=1 here while freezing IF/ID.
REQ-032 load_use SHALL depend only on the current register state and id_* inputs, never on hold/flush (no combinational loop).

Reset
REQ-033 While rstn=0, all stage registers SHALL clear to 0 immediately, independent of clk, so ex_valid, ex_ctrl, ex_aluop, ex_wreg and load_use read 0; reset asserted mid-hold SHALL still clear; the first edge after release SHALL follow REQ-023.

Verification
REQ-034 Plain latch: id_rd1=5, id_rd2=7, alusrc=0, aluop=ADDU, no forwarding match, one edge -> ex_A=5, ex_B=7, ex_valid=1.
REQ-035 Double forward: latched rs=rt=3; mem_wreg=3 with mem_result=0xAA and wb_wreg=3 with wb_result=0xBB, both regwrite=1 -> ex_A=ex_store_data=0xAA; drop mem_regwrite -> 0xBB; set both wreg to 0 -> latched values.
REQ-036 Load-use: EX holds lw to $8, id_rs=8 -> load_use=1; apply flush -> next cycle ex_valid=0, ex_ctrl=0, load_use=0.
REQ-037 hold and flush together -> bubble loaded; hold alone for 3 cycles with changing id_* -> ex_* unchanged.
REQ-038 Immediate/shift: alusrc=1, id_imm=0x00000140 (shamt 5), aluop=SLL -> ex_B=0x140 regardless of forwarding on rt; ex_store_data still forwarded.
REQ-039 Async reset: assert rstn=0 between edges while valid -> outputs 0 before the next edge; release -> normal latching resumes.
